// File: rtl/cr_clic_arb_pipe.sv
// Two-stage pipelined CLIC priority arbiter: per-group winner registered in stage 1,
// cross-group winner plus threshold filter registered to the core-facing outputs.
module cr_clic_arb_pipe #(
  parameter int INTNUM   = 64,
  parameter int CTLBITS  = 3,
  parameter int GRP      = 8,
  parameter int ID_WIDTH = 12
) (
  input  logic                          out_clk,
  input  logic                          cpurst_b,
  input  logic [INTNUM-1:0]             kid_arb_int_req,
  input  logic [INTNUM-1:0]             kid_arb_int_hv,
  input  logic [(CTLBITS+1)*INTNUM-1:0] kid_arb_int_all_vec,
  input  logic [CTLBITS-1:0]            ctrl_xx_int_lv_or_mask,
  input  logic [7:0]                    ctrl_arb_int_th,
  input  logic                          ctrl_arb_int_ack,
  input  logic                          ctrl_arb_flush,
  output logic                          arb_ctrl_int_vld,
  output logic [ID_WIDTH-1:0]           arb_ctrl_int_id,
  output logic [7:0]                    arb_ctrl_int_il,
  output logic                          arb_ctrl_int_mode,
  output logic                          arb_ctrl_int_hv,
  output logic                          out_clk_en
);

  localparam int NGRP = INTNUM / GRP;
  localparam int KW   = CTLBITS + 1;
  localparam int IDXW = (GRP > 1) ? $clog2(GRP) : 1;

  if ((INTNUM % GRP) != 0 || CTLBITS < 1 || CTLBITS > 8) begin : g_param_chk
    $error("cr_clic_arb_pipe: INTNUM must be a multiple of GRP and CTLBITS must be 1..8");
  end

  logic [NGRP-1:0] g_vld;
  logic [KW-1:0]   g_key [NGRP];
  logic [IDXW-1:0] g_idx [NGRP];
  logic [NGRP-1:0] g_hv;

  logic [NGRP-1:0] s1_vld;
  logic [KW-1:0]   s1_key [NGRP];
  logic [IDXW-1:0] s1_idx [NGRP];
  logic [NGRP-1:0] s1_hv;

  logic                best_vld;
  logic [KW-1:0]       best_key;
  logic [ID_WIDTH-1:0] best_id;
  logic                best_hv;
  logic [CTLBITS-1:0]  lv;
  logic [7:0]          il_next;
  logic                vld_next;
  logic [1:0]          bubble_cnt;

  // Strict greater-than keeps the lowest local index on equal keys.
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      g_vld[g] = 1'b0;
      g_key[g] = '0;
      g_idx[g] = '0;
      g_hv[g]  = 1'b0;
      for (int i = 0; i < GRP; i++) begin
        if (kid_arb_int_req[g*GRP+i] &&
            (!g_vld[g] || (kid_arb_int_all_vec[(g*GRP+i)*KW +: KW] > g_key[g]))) begin
          g_vld[g] = 1'b1;
          g_key[g] = kid_arb_int_all_vec[(g*GRP+i)*KW +: KW];
          g_idx[g] = IDXW'(i);
          g_hv[g]  = kid_arb_int_hv[g*GRP+i];
        end
      end
    end
  end

  always_ff @(posedge out_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_vld <= '0;
      s1_hv  <= '0;
      for (int g = 0; g < NGRP; g++) begin
        s1_key[g] <= '0;
        s1_idx[g] <= '0;
      end
    end else if (ctrl_arb_flush) begin
      s1_vld <= '0;
      s1_hv  <= '0;
      for (int g = 0; g < NGRP; g++) begin
        s1_key[g] <= '0;
        s1_idx[g] <= '0;
      end
    end else begin
      s1_vld <= g_vld;
      s1_hv  <= g_hv;
      for (int g = 0; g < NGRP; g++) begin
        s1_key[g] <= g_key[g];
        s1_idx[g] <= g_idx[g];
      end
    end
  end

  always_comb begin
    best_vld = 1'b0;
    best_key = '0;
    best_id  = '0;
    best_hv  = 1'b0;
    for (int g = 0; g < NGRP; g++) begin
      if (s1_vld[g] && (!best_vld || (s1_key[g] > best_key))) begin
        best_vld = 1'b1;
        best_key = s1_key[g];
        best_id  = ID_WIDTH'(g*GRP) + ID_WIDTH'(s1_idx[g]);
        best_hv  = s1_hv[g];
      end
    end
  end

  assign lv = best_key[CTLBITS-1:0] | ctrl_xx_int_lv_or_mask;

  if (CTLBITS < 8) begin : g_il_pad
    assign il_next = {lv, {(8-CTLBITS){1'b1}}};
  end else begin : g_il_full
    assign il_next = lv;
  end

  assign vld_next = best_vld && (il_next > ctrl_arb_int_th) && (bubble_cnt == 2'd0) &&
                    !ctrl_arb_flush && !(arb_ctrl_int_vld && ctrl_arb_int_ack);

  // A taken or flushed interrupt opens a 2-cycle bubble so the kid's cleared pending bit drains.
  always_ff @(posedge out_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      bubble_cnt        <= 2'd0;
      arb_ctrl_int_vld  <= 1'b0;
      arb_ctrl_int_id   <= '0;
      arb_ctrl_int_il   <= 8'd0;
      arb_ctrl_int_mode <= 1'b0;
      arb_ctrl_int_hv   <= 1'b0;
    end else begin
      if (ctrl_arb_flush || (arb_ctrl_int_vld && ctrl_arb_int_ack)) begin
        bubble_cnt <= 2'd2;
      end else if (bubble_cnt != 2'd0) begin
        bubble_cnt <= bubble_cnt - 2'd1;
      end
      arb_ctrl_int_vld <= vld_next;
      if (vld_next) begin
        arb_ctrl_int_id   <= best_id;
        arb_ctrl_int_il   <= il_next;
        arb_ctrl_int_mode <= best_key[CTLBITS];
        arb_ctrl_int_hv   <= best_hv;
      end else begin
        arb_ctrl_int_id   <= '0;
        arb_ctrl_int_il   <= 8'd0;
        arb_ctrl_int_mode <= 1'b0;
        arb_ctrl_int_hv   <= 1'b0;
      end
    end
  end

  assign out_clk_en = (|kid_arb_int_req) | (|s1_vld) | arb_ctrl_int_vld |
                      (bubble_cnt != 2'd0) | ctrl_arb_flush;

endmodule

// File: tb/tb_cr_clic_arb_pipe.sv
// Scoreboard bench for cr_clic_arb_pipe: stimulus queues expected presentations,
// a negedge monitor pops and checks each new presentation including its cycle.
module tb_cr_clic_arb_pipe;

  localparam int INTNUM = 64;
  localparam int CB     = 3;
  localparam int KW     = CB + 1;

  logic                 clk;
  logic                 rst_n;
  logic [INTNUM-1:0]    req;
  logic [INTNUM-1:0]    hv;
  logic [KW*INTNUM-1:0] vec;
  logic [CB-1:0]        mask;
  logic [7:0]           th;
  logic                 ack;
  logic                 flush;
  logic                 vld;
  logic [11:0]          id;
  logic [7:0]           il;
  logic                 mode;
  logic                 hv_o;
  logic                 en;

  cr_clic_arb_pipe #(.INTNUM(INTNUM), .CTLBITS(CB), .GRP(8), .ID_WIDTH(12)) dut (
    .out_clk                (clk),
    .cpurst_b               (rst_n),
    .kid_arb_int_req        (req),
    .kid_arb_int_hv         (hv),
    .kid_arb_int_all_vec    (vec),
    .ctrl_xx_int_lv_or_mask (mask),
    .ctrl_arb_int_th        (th),
    .ctrl_arb_int_ack       (ack),
    .ctrl_arb_flush         (flush),
    .arb_ctrl_int_vld       (vld),
    .arb_ctrl_int_id        (id),
    .arb_ctrl_int_il        (il),
    .arb_ctrl_int_mode      (mode),
    .arb_ctrl_int_hv        (hv_o),
    .out_clk_en             (en)
  );

  typedef struct {
    int         cyc;
    logic [11:0] id;
    logic [7:0]  il;
    logic        mode;
    logic        hv;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  logic p_vld = 1'b0;
  logic [11:0] p_id = '0;
  logic [7:0]  p_il = '0;
  logic p_mode = 1'b0;
  logic p_hv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int s, input logic m, input logic [CB-1:0] lvl, input logic h);
    req[s] = 1'b1;
    hv[s]  = h;
    vec[s*KW +: KW] = {m, lvl};
  endtask

  task automatic clr_src(input int s);
    req[s] = 1'b0;
    hv[s]  = 1'b0;
    vec[s*KW +: KW] = '0;
  endtask

  task automatic expect_pres(input int dcyc, input int eid, input logic [7:0] eil,
                             input logic em, input logic eh);
    exp_t e;
    e.cyc  = cyc + dcyc;
    e.id   = 12'(eid);
    e.il   = eil;
    e.mode = em;
    e.hv   = eh;
    sb.push_back(e);
  endtask

  task automatic idle_chk(input string name);
    @(negedge clk);
    checkOutput(name, {31'd0, vld}, 32'd0);
  endtask

  // Monitor: every new presentation (vld rising or contents changing) consumes one entry.
  always @(negedge clk) begin
    if (vld && (!p_vld || id != p_id || il != p_il || mode != p_mode || hv_o != p_hv)) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("[TB] FAIL unexpected_pres actual id=%0d il=%0h cyc=%0d required none", id, il, cyc);
      end else begin
        m_e = sb.pop_front();
        checkOutput("pres_cyc", cyc, m_e.cyc);
        checkOutput("pres_id", {20'd0, id}, {20'd0, m_e.id});
        checkOutput("pres_il", {24'd0, il}, {24'd0, m_e.il});
        checkOutput("pres_mode", {31'd0, mode}, {31'd0, m_e.mode});
        checkOutput("pres_hv", {31'd0, hv_o}, {31'd0, m_e.hv});
      end
    end
    p_vld  = vld;
    p_id   = id;
    p_il   = il;
    p_mode = mode;
    p_hv   = hv_o;
  end

  initial begin
    rst_n = 1'b0; req = '0; hv = '0; vec = '0; mask = '0;
    th = 8'd0; ack = 1'b0; flush = 1'b0;
    #2;
    checkOutput("rst_vld", {31'd0, vld}, 32'd0);
    checkOutput("rst_id", {20'd0, id}, 32'd0);
    checkOutput("rst_il", {24'd0, il}, 32'd0);
    checkOutput("rst_en", {31'd0, en}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    $display("[TB] single source, ack while idle ignored");
    applyStimulus(5, 1'b0, 3'b101, 1'b1);
    expect_pres(2, 5, 8'hBF, 1'b0, 1'b1);
    step(1); ack = 1'b1;
    step(1); ack = 1'b0;
    step(2);
    clr_src(5);
    step(3);

    $display("[TB] tie-break and replacement");
    applyStimulus(9, 1'b1, 3'b011, 1'b0);
    applyStimulus(11, 1'b1, 3'b011, 1'b0);
    applyStimulus(40, 1'b1, 3'b011, 1'b0);
    expect_pres(2, 9, 8'h7F, 1'b1, 1'b0);
    step(3);
    applyStimulus(17, 1'b1, 3'b110, 1'b0);
    expect_pres(2, 17, 8'hDF, 1'b1, 1'b0);
    step(3);
    clr_src(9); clr_src(11); clr_src(40); clr_src(17);
    step(3);

    $display("[TB] threshold");
    th = 8'h5F;
    applyStimulus(3, 1'b0, 3'b010, 1'b0);
    step(2); idle_chk("th_block_a");
    step(1); idle_chk("th_block_b");
    step(1);
    th = 8'h5E;
    expect_pres(1, 3, 8'h5F, 1'b0, 1'b0);
    step(3);
    clr_src(3); th = 8'd0;
    step(3);

    $display("[TB] level or-mask");
    mask = 3'b100;
    applyStimulus(30, 1'b0, 3'b001, 1'b1);
    expect_pres(2, 30, 8'hBF, 1'b0, 1'b1);
    step(3);
    clr_src(30);
    step(3);
    mask = 3'b000;

    $display("[TB] ack and bubble");
    applyStimulus(12, 1'b0, 3'b111, 1'b0);
    applyStimulus(20, 1'b0, 3'b001, 1'b0);
    expect_pres(2, 12, 8'hFF, 1'b0, 1'b0);
    step(3);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    clr_src(12);
    expect_pres(3, 20, 8'h3F, 1'b0, 1'b0);
    idle_chk("ack_gap1"); step(1);
    idle_chk("ack_gap2"); step(1);
    idle_chk("ack_gap3"); step(3);
    clr_src(20);
    step(3);

    $display("[TB] flush with ack");
    applyStimulus(45, 1'b1, 3'b000, 1'b0);
    expect_pres(2, 45, 8'h1F, 1'b1, 1'b0);
    step(3);
    flush = 1'b1; ack = 1'b1;
    step(1);
    flush = 1'b0; ack = 1'b0;
    expect_pres(3, 45, 8'h1F, 1'b1, 1'b0);
    idle_chk("flush_gap1"); step(1);
    idle_chk("flush_gap2"); step(1);
    idle_chk("flush_gap3"); step(3);

    $display("[TB] clock enable drain");
    clr_src(45);
    @(negedge clk); checkOutput("clken_n0", {31'd0, en}, 32'd1);
    step(1);
    @(negedge clk); checkOutput("clken_n1", {31'd0, en}, 32'd1);
    step(1);
    @(negedge clk); checkOutput("clken_n2", {31'd0, en}, 32'd0);
    step(2);

    $display("[TB] async reset while presenting and mid-bubble");
    applyStimulus(7, 1'b0, 3'b100, 1'b0);
    expect_pres(2, 7, 8'h9F, 1'b0, 1'b0);
    step(3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstp_vld", {31'd0, vld}, 32'd0);
    checkOutput("rstp_id", {20'd0, id}, 32'd0);
    checkOutput("rstp_il", {24'd0, il}, 32'd0);
    checkOutput("rstp_mode", {31'd0, mode}, 32'd0);
    checkOutput("rstp_hv", {31'd0, hv_o}, 32'd0);
    checkOutput("rstp_en", {31'd0, en}, 32'd1);
    #1 rst_n = 1'b1;
    expect_pres(2, 7, 8'h9F, 1'b0, 1'b0);
    step(2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    clr_src(7);
    #1;
    checkOutput("bubble_en", {31'd0, en}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstb_vld", {31'd0, vld}, 32'd0);
    checkOutput("rstb_en", {31'd0, en}, 32'd0);
    #1 rst_n = 1'b1;
    step(4);

    checkOutput("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
